matrix_bank_store: RTL and testbench
====================================

Name: matrix_bank_store

Overview:
- Parametrised multi-slot matrix store for the calculator datapath; successor to the single-buffer matrix storage.
- Holds up to NUM_SLOTS matrices of up to MAX_DIM x MAX_DIM elements, with per-slot metadata (valid, rows, cols).
- Input and display logic stream matrices in and out using valid/ready handshakes.
- Slot allocation is automatic, with oldest-first replacement when every slot is full.

Parameters:
- DATA_W, 8, element width.
- MAX_DIM, 5, maximum rows/cols; must be <= 7.
- NUM_SLOTS, 8, number of matrix slots; must be a power of two and >= 2.
- ID_W, $clog2(NUM_SLOTS), slot-id width.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  reset; asynchronous and active-high.
- wr_start  in  1  pulse; begin a write using wr_m and wr_n.
- wr_m  in  3  rows, valid 1..MAX_DIM.
- wr_n  in  3  cols, valid 1..MAX_DIM.
- wr_valid  in  1  wr_data is valid.
- wr_data  in  DATA_W  element; row-major order.
- wr_ready  out  1  store accepts an element.
- wr_id  out  ID_W  slot allocated to the current/last write.
- wr_done  out  1  one-cycle pulse when the last element is committed.
- rd_start  in  1  pulse; begin a read of slot rd_id.
- rd_id  in  ID_W  slot to read.
- rd_valid  out  1  rd_data is valid.
- rd_data  out  DATA_W  element; row-major order.
- rd_last  out  1  marks the final element of the matrix.
- rd_ready  in  1  consumer accepts rd_data.
- q_id  in  ID_W  metadata query slot.
- q_valid  out  1  queried slot holds a committed matrix (combinational).
- q_m  out  3  rows of queried slot (combinational).
- q_n  out  3  cols of queried slot (combinational).
- used_count  out  ID_W+1  number of valid slots.
- busy  out  1  FSM not IDLE.
- error_flag  out  1  sticky error; cleared by the next accepted command.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; all slot valid bits=0; repl_ptr=0.
  - All outputs 0: wr_ready, wr_done, wr_id, rd_valid, rd_data, rd_last, busy, error_flag, used_count.
  - Element storage contents are not cleared.
  - Reset mid-transfer aborts the transfer; no slot becomes valid.
- FSM states: IDLE, WRITE, READ. Commands are sampled only in IDLE.
  - If wr_start and rd_start are both high, wr_start wins and rd_start is ignored (not an error).
  - Commands asserted outside IDLE are ignored.
- Write accept (IDLE, wr_start):
  - If wr_m or wr_n is 0 or > MAX_DIM: error_flag=1, stay IDLE.
  - Otherwise latch m and n, then allocate a slot:
    - lowest-index slot with valid=0, if one exists;
    - else slot repl_ptr, then repl_ptr <= repl_ptr+1 (mod NUM_SLOTS).
  - The allocated slot's valid is cleared immediately; used_count is updated the same cycle.
  - wr_id registered; error_flag=0; go to WRITE.
- WRITE:
  - wr_ready=1. Each cycle with wr_valid & wr_ready stores the element at slot*MAX_DIM*MAX_DIM + idx, then idx++.
  - When idx reaches m*n-1 and that element is accepted:
    - slot valid=1 with stored m, n;
    - wr_done pulses the next cycle;
    - wr_ready drops and the FSM returns to IDLE.
  - Elements beyond m*n are never accepted.
- Read accept (IDLE, rd_start, no wr_start):
  - If slot rd_id is invalid: error_flag=1, stay IDLE.
  - Otherwise error_flag=0, idx=0, go to READ.
- READ:
  - Storage has combinational read into a registered output.
  - rd_valid rises the cycle after the accept and carries element 0.
  - Output holds stable while rd_valid & !rd_ready.
  - On each rd_valid & rd_ready, the next element loads the following cycle, so throughput is 1 element/cycle with rd_ready held high.
  - rd_last=1 with element m*n-1. Its handshake clears rd_valid and rd_last and returns the FSM to IDLE.
- Index arithmetic: idx width covers MAX_DIM*MAX_DIM-1; m*n is computed at full width (6 bits for MAX_DIM=7).
- busy=1 in WRITE and READ.
- Query port is purely combinational from the metadata registers. A slot being rewritten reports q_valid=0.
- used_count = popcount of slot valid bits; it never exceeds NUM_SLOTS.

Test Plan:
- Reset, then write 2x3 with data 1..6 -> wr_id=0; wr_done pulses after 6th accept; q_id=0 gives q_valid=1, q_m=2, q_n=3; used_count=1.
- Read slot 0 with rd_ready toggling 1,0,1,0... -> rd_data 1..6 in order, each held during stall; rd_last only on 6; busy drops after the final handshake.
- Write 9 matrices (1x1, data=k) into 8 slots -> ids 0..7 then 0; read slot 0 returns 9; used_count=8; repl_ptr=1.
- wr_start with wr_m=0, then rd_start on an empty slot -> error_flag=1 each time, FSM stays IDLE; next valid write clears error_flag.
- Assert rst mid-WRITE after 3 of 25 elements (5x5) -> outputs 0, q_valid=0 for that slot, used_count=0; next write allocates slot 0.
- wr_start and rd_start in the same cycle, then rd_start during WRITE -> write proceeds, read ignored, error_flag stays 0.

Source files
------------

// File: rtl/matrix_bank_store.sv
// Multi-slot matrix store: NUM_SLOTS matrices of up to MAX_DIM x MAX_DIM elements,
// streamed in and out over valid/ready, with lowest-free / oldest-first slot allocation.
`timescale 1ns/1ps
module matrix_bank_store #(
   parameter int DATA_W    = 8,
   parameter int MAX_DIM   = 5,
   parameter int NUM_SLOTS = 8,
   parameter int ID_W      = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_start,
   input  logic [2:0]        wr_m,
   input  logic [2:0]        wr_n,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic [ID_W-1:0]   wr_id,
   output logic              wr_done,
   input  logic              rd_start,
   input  logic [ID_W-1:0]   rd_id,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   input  logic              rd_ready,
   input  logic [ID_W-1:0]   q_id,
   output logic              q_valid,
   output logic [2:0]        q_m,
   output logic [2:0]        q_n,
   output logic [ID_W:0]     used_count,
   output logic              busy,
   output logic              error_flag
);
   localparam int AREA  = MAX_DIM * MAX_DIM;
   localparam int DEPTH = NUM_SLOTS * AREA;
   localparam int AW    = $clog2(DEPTH);
   localparam int IDX_W = (AREA > 1) ? $clog2(AREA) : 1;
   localparam int MN_W  = 6;
   localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t              r_state;
   logic [NUM_SLOTS-1:0] r_valid;
   logic [2:0]          r_slot_m [NUM_SLOTS];
   logic [2:0]          r_slot_n [NUM_SLOTS];
   logic [ID_W-1:0]     r_repl_ptr;
   logic [ID_W-1:0]     r_wr_id;
   logic [ID_W-1:0]     r_rd_slot;
   logic [2:0]          r_cur_m;
   logic [2:0]          r_cur_n;
   logic [MN_W-1:0]     r_last_idx;
   logic [IDX_W-1:0]    r_idx;
   logic                r_wr_done;
   logic                r_rd_valid;
   logic                r_rd_last;
   logic [DATA_W-1:0]   r_rd_data;
   logic                r_err;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_dims_ok;
   logic [MN_W-1:0]     w_wr_mn;
   logic [MN_W-1:0]     w_rd_mn;
   logic                w_at_last;
   logic                w_free_found;
   logic [ID_W-1:0]     w_free_slot;
   logic [ID_W-1:0]     w_alloc_slot;
   logic [AW-1:0]       w_wr_addr;
   logic [AW-1:0]       w_rd_addr;
   logic [ID_W:0]       w_used;

   assign w_dims_ok = (wr_m != 3'd0) && (wr_m <= DIM_MAX) &&
                      (wr_n != 3'd0) && (wr_n <= DIM_MAX);
   assign w_wr_mn   = MN_W'(wr_m) * MN_W'(wr_n);
   assign w_rd_mn   = MN_W'(r_slot_m[rd_id]) * MN_W'(r_slot_n[rd_id]);
   assign w_at_last = (MN_W'(r_idx) == r_last_idx);
   assign w_wr_addr = AW'(r_wr_id) * AW'(AREA) + AW'(r_idx);
   // In IDLE the address points at element 0 of the requested slot; in READ at the next element.
   assign w_rd_addr = (r_state == S_IDLE) ? AW'(rd_id) * AW'(AREA)
                                          : AW'(r_rd_slot) * AW'(AREA) + AW'(r_idx) + AW'(1);

   always_comb begin
      w_free_found = 1'b0;
      w_free_slot  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_free_found = 1'b1;
            w_free_slot  = ID_W'(i);
         end
      end
   end

   assign w_alloc_slot = w_free_found ? w_free_slot : r_repl_ptr;

   always_comb begin
      w_used = '0;
      for (int i = 0; i < NUM_SLOTS; i++) w_used = w_used + (ID_W+1)'(r_valid[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_repl_ptr <= '0;
         r_wr_id    <= '0;
         r_rd_slot  <= '0;
         r_cur_m    <= '0;
         r_cur_n    <= '0;
         r_last_idx <= '0;
         r_idx      <= '0;
         r_wr_done  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_data  <= '0;
         r_err      <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_slot_m[i] <= '0;
            r_slot_n[i] <= '0;
         end
      end else begin
         r_wr_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (wr_start) begin
                  if (!w_dims_ok) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err                 <= 1'b0;
                     r_cur_m               <= wr_m;
                     r_cur_n               <= wr_n;
                     r_last_idx            <= w_wr_mn - MN_W'(1);
                     r_idx                 <= '0;
                     r_wr_id               <= w_alloc_slot;
                     r_valid[w_alloc_slot] <= 1'b0;
                     if (!w_free_found) r_repl_ptr <= r_repl_ptr + 1'b1;
                     r_state               <= S_WRITE;
                  end
               end else if (rd_start) begin
                  if (!r_valid[rd_id]) begin
                     r_err <= 1'b1;
                  end else begin
                     r_err      <= 1'b0;
                     r_rd_slot  <= rd_id;
                     r_idx      <= '0;
                     r_last_idx <= w_rd_mn - MN_W'(1);
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= r_mem[w_rd_addr];
                     r_rd_last  <= (w_rd_mn == MN_W'(1));
                     r_state    <= S_READ;
                  end
               end
            end
            S_WRITE: begin
               if (wr_valid) begin
                  if (w_at_last) begin
                     r_valid[r_wr_id]  <= 1'b1;
                     r_slot_m[r_wr_id] <= r_cur_m;
                     r_slot_n[r_wr_id] <= r_cur_n;
                     r_wr_done         <= 1'b1;
                     r_state           <= S_IDLE;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_READ: begin
               // rd_valid is held high for the whole READ state, so rd_ready alone is the handshake.
               if (rd_ready) begin
                  if (r_rd_last) begin
                     r_rd_valid <= 1'b0;
                     r_rd_last  <= 1'b0;
                     r_state    <= S_IDLE;
                  end else begin
                     r_idx     <= r_idx + 1'b1;
                     r_rd_data <= r_mem[w_rd_addr];
                     r_rd_last <= ((MN_W'(r_idx) + MN_W'(1)) == r_last_idx);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_WRITE && wr_valid) r_mem[w_wr_addr] <= wr_data;
   end

   assign wr_ready   = (r_state == S_WRITE);
   assign wr_id      = r_wr_id;
   assign wr_done    = r_wr_done;
   assign rd_valid   = r_rd_valid;
   assign rd_data    = r_rd_data;
   assign rd_last    = r_rd_last;
   assign q_valid    = r_valid[q_id];
   assign q_m        = r_slot_m[q_id];
   assign q_n        = r_slot_n[q_id];
   assign used_count = w_used;
   assign busy       = (r_state != S_IDLE);
   assign error_flag = r_err;

endmodule

// File: tb/tb_matrix_bank_store.sv
// Bench for matrix_bank_store: directed scenarios plus randomized traffic checked
// against an array-based model of slots, allocation and contents.
`timescale 1ns/1ps
module tb_matrix_bank_store;
   localparam int DATA_W = 8;
   localparam int MAX_DIM = 5;
   localparam int NS = 8;
   localparam int ID_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              wr_start = 1'b0;
   logic [2:0]        wr_m = '0;
   logic [2:0]        wr_n = '0;
   logic              wr_valid = 1'b0;
   logic [DATA_W-1:0] wr_data = '0;
   logic              wr_ready;
   logic [ID_W-1:0]   wr_id;
   logic              wr_done;
   logic              rd_start = 1'b0;
   logic [ID_W-1:0]   rd_id = '0;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              rd_ready = 1'b0;
   logic [ID_W-1:0]   q_id = '0;
   logic              q_valid;
   logic [2:0]        q_m;
   logic [2:0]        q_n;
   logic [ID_W:0]     used_count;
   logic              busy;
   logic              error_flag;

   int checks = 0;
   int errors = 0;

   // Reference model
   bit   mv [NS];
   int   mm [NS];
   int   mn [NS];
   logic [7:0] md [NS][25];
   int   mptr;
   logic [7:0] wbuf [25];

   matrix_bank_store #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM), .NUM_SLOTS(NS), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst), .wr_start(wr_start), .wr_m(wr_m), .wr_n(wr_n),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_id(wr_id),
      .wr_done(wr_done), .rd_start(rd_start), .rd_id(rd_id), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready), .q_id(q_id),
      .q_valid(q_valid), .q_m(q_m), .q_n(q_n), .used_count(used_count),
      .busy(busy), .error_flag(error_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < NS; i++) c += int'(mv[i]);
      return c;
   endfunction

   function automatic int model_alloc();
      int r;
      for (int i = 0; i < NS; i++) if (!mv[i]) return i;
      r = mptr;
      mptr = (mptr + 1) % NS;
      mv[r] = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) mv[i] = 1'b0;
      mptr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_start = 1'b0; rd_start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      step();
      step();
      model_reset();
      rst = 1'b0;
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_ready"}, wr_ready, 0);
      check({tag, "_wr_done"}, wr_done, 0);
      check({tag, "_wr_id"}, wr_id, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_rd_last"}, rd_last, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_error_flag"}, error_flag, 0);
      check({tag, "_used_count"}, used_count, 0);
   endtask

   // Writes an m x n matrix from wbuf; with_rd also raises rd_start throughout the transfer.
   task automatic do_write(input int m, input int n, input bit with_rd);
      int exp_id;
      int k = 0;
      int cyc = 0;
      exp_id = model_alloc();
      wr_m = 3'(m); wr_n = 3'(n); wr_start = 1'b1; rd_start = with_rd;
      step();
      wr_start = 1'b0;
      check("wr_id", wr_id, exp_id);
      check("wr_busy", busy, 1);
      check("wr_err_clear", error_flag, 0);
      check("wr_used_on_alloc", used_count, model_count());
      while (k < m * n && cyc < 300) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data = wbuf[k];
         check("wr_ready", wr_ready, 1);
         check("wr_done_early", wr_done, 0);
         if (with_rd) begin
            check("wr_rd_ignored", rd_valid, 0);
            check("wr_rd_err", error_flag, 0);
         end
         step();
         if (wr_valid) k++;
         cyc++;
      end
      wr_valid = 1'b0; rd_start = 1'b0;
      check("wr_elem_count", k, m * n);
      mv[exp_id] = 1'b1; mm[exp_id] = m; mn[exp_id] = n;
      for (int i = 0; i < m * n; i++) md[exp_id][i] = wbuf[i];
      check("wr_done_pulse", wr_done, 1);
      check("wr_ready_drop", wr_ready, 0);
      check("wr_idle", busy, 0);
      check("wr_used", used_count, model_count());
      step();
      check("wr_done_one_cycle", wr_done, 0);
      q_id = 3'(exp_id);
      #1;
      check("q_valid", q_valid, 1);
      check("q_m", q_m, m);
      check("q_n", q_n, n);
   endtask

   task automatic bad_write(input int m, input int n);
      int used0;
      used0 = model_count();
      wr_m = 3'(m); wr_n = 3'(n); wr_start = 1'b1;
      step();
      wr_start = 1'b0;
      check("badwr_err", error_flag, 1);
      check("badwr_busy", busy, 0);
      check("badwr_ready", wr_ready, 0);
      check("badwr_used", used_count, used0);
   endtask

   // mode: 0 = rd_ready toggles 1,0,1,..; 1 = random; 2 = always high. inject raises wr_start during the read.
   task automatic do_read(input int s, input int mode, input bit inject);
      int cnt = 0;
      int cyc = 0;
      int tot;
      rd_id = 3'(s); rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      if (!mv[s]) begin
         check("rd_bad_err", error_flag, 1);
         check("rd_bad_busy", busy, 0);
         check("rd_bad_valid", rd_valid, 0);
         return;
      end
      tot = mm[s] * mn[s];
      check("rd_err_clear", error_flag, 0);
      check("rd_busy", busy, 1);
      wr_m = 3'd1; wr_n = 3'd1; wr_start = inject;
      while (cnt < tot && cyc < 300) begin
         case (mode)
            0: rd_ready = (cyc % 2 == 0);
            1: rd_ready = 1'($urandom_range(0, 1));
            default: rd_ready = 1'b1;
         endcase
         check("rd_valid", rd_valid, 1);
         check("rd_data", rd_data, md[s][cnt]);
         check("rd_last", rd_last, (cnt == tot - 1) ? 1 : 0);
         check("rd_used", used_count, model_count());
         step();
         if (rd_ready) cnt++;
         cyc++;
      end
      rd_ready = 1'b0; wr_start = 1'b0;
      check("rd_elem_count", cnt, tot);
      check("rd_end_valid", rd_valid, 0);
      check("rd_end_last", rd_last, 0);
      check("rd_end_busy", busy, 0);
   endtask

   task automatic check_all_meta();
      for (int i = 0; i < NS; i++) begin
         q_id = 3'(i);
         #1;
         check("meta_valid", q_valid, mv[i]);
         if (mv[i]) begin
            check("meta_m", q_m, mm[i]);
            check("meta_n", q_n, mn[i]);
         end
      end
   endtask

   initial begin
      int op, s, m, n;
      model_reset();
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      step();

      // 2x3 write of 1..6, read back with toggling ready
      for (int i = 0; i < 6; i++) wbuf[i] = 8'(i + 1);
      do_write(2, 3, 1'b0);
      check("first_id", wr_id, 0);
      do_read(0, 0, 1'b0);

      // Nine 1x1 writes into eight slots, then one more to observe the replacement pointer
      do_reset();
      for (int k = 1; k <= 9; k++) begin
         wbuf[0] = 8'(k);
         do_write(1, 1, 1'b0);
      end
      check("full_used", used_count, 8);
      do_read(0, 2, 1'b0);
      wbuf[0] = 8'd10;
      do_write(1, 1, 1'b0);
      check("repl_next_id", wr_id, 1);

      // Error handling and clearing
      do_reset();
      bad_write(0, 3);
      do_read(3, 2, 1'b0);
      bad_write(2, 6);
      bad_write(7, 1);
      for (int i = 0; i < 25; i++) wbuf[i] = 8'($urandom);
      do_write(3, 2, 1'b0);
      do_read(0, 1, 1'b1);

      // Reset in the middle of a 5x5 write
      do_reset();
      wr_m = 3'd5; wr_n = 3'd5; wr_start = 1'b1;
      step();
      wr_start = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'(i + 40);
         step();
      end
      rst = 1'b1;
      wr_valid = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      q_id = '0;
      #1;
      check("midrst_q_valid", q_valid, 0);
      step();
      rst = 1'b0;
      step();
      for (int i = 0; i < 25; i++) wbuf[i] = 8'($urandom);
      do_write(5, 5, 1'b0);
      check("midrst_next_id", wr_id, 0);
      do_read(0, 1, 1'b0);

      // Simultaneous commands: write wins, reads during WRITE ignored
      for (int i = 0; i < 25; i++) wbuf[i] = 8'($urandom);
      rd_id = '0;
      do_write(2, 2, 1'b1);
      check("simul_id", wr_id, 1);
      check("simul_err", error_flag, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 4) begin
            m = int'($urandom_range(1, MAX_DIM));
            n = int'($urandom_range(1, MAX_DIM));
            for (int i = 0; i < 25; i++) wbuf[i] = 8'($urandom);
            do_write(m, n, 1'($urandom_range(0, 1)));
         end else if (op <= 8) begin
            s = int'($urandom_range(0, NS - 1));
            do_read(s, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         end else begin
            bad_write(0, int'($urandom_range(1, 7)));
         end
      end
      check_all_meta();
      step();
      check("final_used", used_count, model_count());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
